// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file geometry, hazard-unit defaults and forwarding-source indices.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SB_CNT_W = 2;
  localparam int FWD_EX = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB = 2;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dest;
    logic rs_used;
    logic rt_used;
    logic long_op;
  } instr_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: picks the youngest forwarding source whose destination matches one operand.
module fwd_select import cpu_pkg::*; #(
  parameter int NUM_FWD = 3,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [REG_ADDR_W-1:0]         i_addr,
  input  logic [NUM_FWD-1:0]            i_fwd_valid,
  input  logic [NUM_FWD-1:0]            i_fwd_ready,
  input  logic [REG_ADDR_W*NUM_FWD-1:0] i_fwd_dest,
  input  logic [DATA_W*NUM_FWD-1:0]     i_fwd_data,
  output logic                          o_hit,
  output logic                          o_hit_ready,
  output logic [DATA_W-1:0]             o_data
);
  // Walk oldest to youngest so the lowest matching index overrides.
  always_comb begin
    o_hit = 1'b0;
    o_hit_ready = 1'b0;
    o_data = '0;
    for (int i = NUM_FWD-1; i >= 0; i--) begin
      if (i_fwd_valid[i] && i_fwd_dest[i*REG_ADDR_W +: REG_ADDR_W] == i_addr) begin
        o_hit = 1'b1;
        o_hit_ready = i_fwd_ready[i];
        o_data = i_fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end
endmodule

// File: rtl/ds_hazard_unit.sv
// ds_hazard_unit: one-entry operand-resolve stage with forwarding and a long-latency scoreboard.
// Define DS_HAZARD_FWD_EN to forward ready results; otherwise any in-flight writer stalls.
module ds_hazard_unit import cpu_pkg::*; #(
  parameter int NUM_FWD = 3,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SB_CNT_W = DEF_SB_CNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [REG_ADDR_W-1:0]         in_rs,
  input  logic [REG_ADDR_W-1:0]         in_rt,
  input  logic [REG_ADDR_W-1:0]         in_dest,
  input  logic                          in_rs_used,
  input  logic                          in_rt_used,
  input  logic                          in_long,
  input  logic [DATA_W-1:0]             rf_rdata1,
  input  logic [DATA_W-1:0]             rf_rdata2,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD-1:0]            fwd_ready,
  input  logic [REG_ADDR_W*NUM_FWD-1:0] fwd_dest,
  input  logic [DATA_W*NUM_FWD-1:0]     fwd_data,
  input  logic                          cpl_valid,
  input  logic [REG_ADDR_W-1:0]         cpl_dest,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_rs_value,
  output logic [DATA_W-1:0]             out_rt_value,
  output logic [31:0]                   stall_cnt
);
  instr_t r_ins;
  logic r_v;
  logic [SB_CNT_W-1:0] r_cnt [NUM_REGS];
  logic [31:0] r_stall;
  logic w_rs_hit, w_rs_rdy, w_rt_hit, w_rt_rdy;
  logic [DATA_W-1:0] w_rs_fwd, w_rt_fwd;
  logic w_rs_stall, w_rt_stall, w_go, w_fire, w_inc;
  logic [NUM_REGS-1:0] w_inc_vec, w_dec_vec;
`ifdef DS_HAZARD_FWD_EN
  fwd_select #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W)) u_rs_sel (
    .i_addr(r_ins.rs), .i_fwd_valid(fwd_valid), .i_fwd_ready(fwd_ready),
    .i_fwd_dest(fwd_dest), .i_fwd_data(fwd_data),
    .o_hit(w_rs_hit), .o_hit_ready(w_rs_rdy), .o_data(w_rs_fwd)
  );
  fwd_select #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W)) u_rt_sel (
    .i_addr(r_ins.rt), .i_fwd_valid(fwd_valid), .i_fwd_ready(fwd_ready),
    .i_fwd_dest(fwd_dest), .i_fwd_data(fwd_data),
    .o_hit(w_rt_hit), .o_hit_ready(w_rt_rdy), .o_data(w_rt_fwd)
  );
`else
  logic w_unused;
  assign w_unused = ^{fwd_ready, fwd_data};
  assign w_rs_rdy = 1'b0;
  assign w_rt_rdy = 1'b0;
  assign w_rs_fwd = '0;
  assign w_rt_fwd = '0;
  always_comb begin
    w_rs_hit = 1'b0;
    w_rt_hit = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      w_rs_hit = w_rs_hit | (fwd_valid[i] && fwd_dest[i*REG_ADDR_W +: REG_ADDR_W] == r_ins.rs);
      w_rt_hit = w_rt_hit | (fwd_valid[i] && fwd_dest[i*REG_ADDR_W +: REG_ADDR_W] == r_ins.rt);
    end
  end
`endif
  // A matched source decides the operand outright; only unmatched operands consult the scoreboard.
  assign w_rs_stall = r_ins.rs_used && r_ins.rs != '0 && (w_rs_hit ? !w_rs_rdy : r_cnt[r_ins.rs] != '0);
  assign w_rt_stall = r_ins.rt_used && r_ins.rt != '0 && (w_rt_hit ? !w_rt_rdy : r_cnt[r_ins.rt] != '0);
  assign w_go = !w_rs_stall && !w_rt_stall && !(r_ins.long_op && r_ins.dest != '0 && &r_cnt[r_ins.dest]);
  assign out_valid = r_v && w_go && !flush;
  assign in_ready = !r_v || (w_go && out_ready && !flush);
  assign w_fire = out_valid && out_ready;
  assign w_inc = w_fire && r_ins.long_op && r_ins.dest != '0;
  assign w_inc_vec = w_inc ? NUM_REGS'(1) << r_ins.dest : '0;
  assign w_dec_vec = cpl_valid ? NUM_REGS'(1) << cpl_dest : '0;
  assign out_rs_value = r_ins.rs == '0 ? '0 : (w_rs_hit && w_rs_rdy) ? w_rs_fwd : rf_rdata1;
  assign out_rt_value = r_ins.rt == '0 ? '0 : (w_rt_hit && w_rt_rdy) ? w_rt_fwd : rf_rdata2;
  assign stall_cnt = r_stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= 1'b0;
      r_stall <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else begin
      r_v <= (in_valid && in_ready) ? 1'b1 : (flush || w_fire) ? 1'b0 : r_v;
      if (r_v && !w_go && !flush) r_stall <= r_stall + 32'd1;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_inc_vec[i] && !w_dec_vec[i]) r_cnt[i] <= r_cnt[i] + SB_CNT_W'(1);
        else if (w_dec_vec[i] && !w_inc_vec[i] && r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - SB_CNT_W'(1);
      end
    end
    if (in_valid && in_ready)
      r_ins <= '{rs: in_rs, rt: in_rt, dest: in_dest, rs_used: in_rs_used, rt_used: in_rt_used, long_op: in_long};
  end
endmodule
